// File: rtl/vedic_seq_mult.sv
// Sequential N x N unsigned multiplier, Urdhva-Tiryakbhyam (vertical-and-crosswise).
// One product column is reduced per clock: the column's partial products plus the
// carry from the previous column. The result is presented on a valid/ready port.
module vedic_seq_mult #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned KW = $clog2(2 * N);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [KW-1:0] KLast = KW'(2 * N - 2);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e           state_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    carry_q;
  logic [2*N-1:0]   product_q;
  logic [SW-1:0]    col_sum;

  // Column k: carry-in plus every a[i]&b[k-i] whose index pair is in range.
  always_comb begin
    col_sum = {1'b0, carry_q};
    for (int i = 0; i < N; i++) begin
      if ((KW'(i) <= k_q) && ((k_q - KW'(i)) < KW'(N))) begin
        col_sum = col_sum + SW'(a_q[i] & b_q[IW'(k_q - KW'(i))]);
      end
    end
  end

  // Control FSM and datapath registers; column bit and carry are written each COMPUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            k_q       <= '0;
            carry_q   <= '0;
            product_q <= '0;
            state_q   <= StCompute;
          end
        end
        StCompute: begin
          product_q[k_q] <= col_sum[0];
          carry_q        <= col_sum[SW-1:1];
          k_q            <= k_q + 1'b1;
          if (k_q == KLast) begin
            // Last column: its carry is the product MSB; higher carry bits are always zero.
            product_q[2*N-1] <= col_sum[1];
            state_q          <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StCompute);
  assign out_valid = (state_q == StDone);
  assign product   = product_q;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Self-checking bench for vedic_seq_mult: N=4 directed table, corner sequences and
// exhaustive sweep, plus random N=8 products, all checked through a scoreboard queue.
module tb_vedic_seq_mult;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  a, b;
  logic [7:0]  product;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp8_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int         hold;
  } vec_t;

  vec_t vecs[5];

  vedic_seq_mult #(.N(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  vedic_seq_mult #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // The last column's carry must fit in one bit: upper carry bits are zero.
  always @(negedge clk) begin
    if (!rst && busy && dut4.k_q == 3'd6) chk("carry4_hi", dut4.col_sum >> 2, 0);
    if (!rst && busy8 && dut8.k_q == 4'd14) chk("carry8_hi", dut8.col_sum >> 2, 0);
  end

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] expv,
                        input int hold, input bit timing, input string name);
    int cyc;
    logic [15:0] e;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (timing) chk({name, "_idle_ready"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({8'h00, expv});
    if (timing) begin
      chk({name, "_ready_drop"}, in_ready, 0);
      chk({name, "_busy"}, busy, 1);
    end
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, "_out_valid"}, out_valid, 1);
    if (timing) chk({name, "_latency"}, cyc, 7);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_prod"}, product, expv);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    chk({name, "_product"}, product, e);
    @(posedge clk); #1;
    if (timing) begin
      chk({name, "_back_idle"}, in_ready, 1);
      chk({name, "_valid_drop"}, out_valid, 0);
      chk({name, "_prod_kept"}, product, expv);
    end
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
    int cyc;
    logic [15:0] e;
    cyc = 0;
    while (!in_ready8 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    a8 = av; b8 = bv; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    exp8_q.push_back(16'(av) * 16'(bv));
    cyc = 0;
    while (!out_valid8 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("n8_latency", cyc, 15);
    e = (exp8_q.size() > 0) ? exp8_q.pop_front() : 16'hFFFF;
    chk("n8_product", product8, e);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    logic [15:0] e;

    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1, hold: 0};
    vecs[1] = '{a: 4'd13, b: 4'd11, p: 8'h8F, hold: 0};
    vecs[2] = '{a: 4'd1,  b: 4'd9,  p: 8'd9,  hold: 0};
    vecs[3] = '{a: 4'd0,  b: 4'd12, p: 8'd0,  hold: 0};
    vecs[4] = '{a: 4'd6,  b: 4'd7,  p: 8'd42, hold: 5};

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0;
    #8;
    chk("rst_product", product, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].hold, 1'b1, $sformatf("vec%0d", v));
    end

    // Operands and in_valid wiggling during COMPUTE must not disturb the result.
    a = 4'd9; b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(16'd45);
    a = 4'd15; b = 4'd15;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("corrupt_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    cyc = 3;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("corrupt_latency", cyc, 7);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    chk("corrupt_product", product, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("corrupt_no_restart", busy, 0);

    // Asynchronous reset three cycles into COMPUTE discards the operation.
    a = 4'd7; b = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    #3 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    run_op(4'd3, 4'd3, 8'd9, 0, 1'b1, "post_rst");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 8'(i * j), 0, 1'b0, "sweep");
      end
    end

    run_op8(8'd255, 8'd255);
    run_op8(8'd0, 8'd200);
    run_op8(8'd1, 8'd173);
    for (int r = 0; r < 100; r++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    chk("scoreboard_empty", exp_q.size() + exp8_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
